// File: rtl/alu_arb_pkg.sv
`default_nettype none
//============================================================================
// Module      : alu_arb_pkg
// Description : Shared types and helpers for the round-robin ALU arbiter:
//               controller state encoding, opcode type, index-width helper.
// Revision    : 1.0 - initial release
//============================================================================
package alu_arb_pkg;

    localparam int c_op_w = 3;

    // Explicit state encodings so the FSM width is fixed at two bits.
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = c_st_idle,
        ISSUE = c_st_issue,
        WAIT  = c_st_wait,
        RESP  = c_st_resp
    } state_t;

    typedef logic [c_op_w-1:0] alu_op_t;

    // Width of an index able to address n requesters (never below one bit).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
//============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin picker. Returns the first
//               requester with req set, searching upward from ptr with
//               wrap-around, as both a one-hot grant and a binary index.
// Revision    : 1.0 - initial release
//============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    // Walk the rotated order from farthest to nearest so the requester
    // closest to the pointer is the last (winning) assignment.
    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req[j]) begin
                grant     = '0;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
                any       = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
//============================================================================
// Module      : alu_arbiter
// Description : Shares one ALU among NUM_REQ requesters. Accepts one request
//               at a time (round-robin), latches its operands, pulses
//               alu_start, waits for alu_done and returns the held result to
//               the granted requester over a valid/ready response channel.
//               Optional feature macro: ALU_ARB_TIMEOUT_EN (WAIT watchdog of
//               TIMEOUT_CYC cycles, reported through rsp_err).
// Revision    : 1.0 - initial release
//============================================================================
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int OP_W        = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      alu_start,
    output logic [OP_W-1:0]           alu_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    input  logic                      alu_done,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_carry,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_carry,
    output logic                      rsp_err
);

    localparam int c_idx_w = idx_width(NUM_REQ);

    state_t               r_state;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [c_idx_w-1:0]   r_grant_idx;
    logic [NUM_REQ-1:0]   r_grant_oh;
    logic                 r_alu_start;
    logic [OP_W-1:0]      r_alu_op;
    logic [DATA_W-1:0]    r_alu_a;
    logic [DATA_W-1:0]    r_alu_b;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_result;
    logic                 r_rsp_carry;

    logic [NUM_REQ-1:0]   w_grant_oh;
    logic [c_idx_w-1:0]   w_grant_idx;
    logic                 w_any;
    logic                 w_accept;
    logic                 w_rsp_hs;
    logic [c_idx_w-1:0]   w_ptr_next;
    logic [OP_W-1:0]      w_sel_op;
    logic [DATA_W-1:0]    w_sel_a;
    logic [DATA_W-1:0]    w_sel_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant_oh),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    // Only the winner sees ready, and only while idle and out of reset.
    assign req_ready  = (r_state == IDLE && !rst) ? w_grant_oh : '0;
    assign w_accept   = (r_state == IDLE) && w_any;
    // r_rsp_valid is non-zero only in RESP, so this also masks other states.
    assign w_rsp_hs   = |(rsp_ready & r_rsp_valid);
    assign w_ptr_next = (r_grant_idx == c_idx_w'(NUM_REQ - 1)) ? '0
                                                               : r_grant_idx + 1'b1;

    // Steer the winning requester's slice of the packed operand buses.
    always_comb begin
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_op = req_op[i*OP_W +: OP_W];
                w_sel_a  = req_a[i*DATA_W +: DATA_W];
                w_sel_b  = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYC + 1);

    logic [c_to_w-1:0] r_to_cnt;
    logic              r_rsp_err;
    logic              w_to_hit;

    // Counter holds (WAIT cycles seen - 1); the limit is hit on cycle TIMEOUT_CYC.
    assign w_to_hit = (r_to_cnt == c_to_w'(TIMEOUT_CYC - 1));
    assign rsp_err  = r_rsp_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYC > 0);
    assign rsp_err          = 1'b0;
`endif

    // Controller FSM with operand latches, result hold registers and pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_grant_idx  <= '0;
            r_grant_oh   <= '0;
            r_alu_start  <= 1'b0;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
            r_to_cnt     <= '0;
            r_rsp_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_op    <= w_sel_op;
                        r_alu_a     <= w_sel_a;
                        r_alu_b     <= w_sel_b;
                        r_grant_idx <= w_grant_idx;
                        r_grant_oh  <= w_grant_oh;
                        r_alu_start <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // alu_done during the start pulse is deliberately ignored.
                    r_alu_start <= 1'b0;
                    r_state     <= WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
                    r_to_cnt    <= '0;
`endif
                end
                WAIT: begin
                    if (alu_done) begin
                        r_rsp_result <= alu_result;
                        r_rsp_carry  <= alu_carry;
                        r_rsp_valid  <= r_grant_oh;
                        r_state      <= RESP;
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    else if (w_to_hit) begin
                        r_rsp_result <= '0;
                        r_rsp_carry  <= 1'b0;
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= r_grant_oh;
                        r_state      <= RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= '0;
                        r_rr_ptr    <= w_ptr_next;
                        r_state     <= IDLE;
`ifdef ALU_ARB_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_start  = r_alu_start;
    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. Contains a behavioural
//               ALU, a round-robin reference model and directed plus
//               randomized transactions.
// Revision    : 1.0 - initial release
//============================================================================
module tb_alu_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 8;
    localparam int OP_W        = 3;
    localparam int TIMEOUT_CYC = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      alu_start;
    logic [OP_W-1:0]           alu_op;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic                      alu_done;
    logic [DATA_W-1:0]         alu_result;
    logic                      alu_carry;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_carry;
    logic                      rsp_err;

    // Reference model state: per-requester operands and the rotation pointer.
    logic [OP_W-1:0]   m_op [NUM_REQ];
    logic [DATA_W-1:0] m_a  [NUM_REQ];
    logic [DATA_W-1:0] m_b  [NUM_REQ];
    int                m_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .OP_W        (OP_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural ALU: {carry, result}.
    function automatic logic [DATA_W:0] alu_ref(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {a, 1'b0};
            3'd6:    return {a[0], 1'b0, a[DATA_W-1:1]};
            default: return {1'b0, ~a};
        endcase
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] o;
        o    = '0;
        o[i] = 1'b1;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_op[i*OP_W +: OP_W]     = m_op[i];
            req_a[i*DATA_W +: DATA_W]  = m_a[i];
            req_b[i*DATA_W +: DATA_W]  = m_b[i];
        end
    endtask

    task automatic set_req(input int i, input logic [OP_W-1:0] op,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        m_op[i] = op;
        m_a[i]  = a;
        m_b[i]  = b;
        drive();
    endtask

    task automatic randomize_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            m_op[i] = OP_W'($urandom);
            m_a[i]  = DATA_W'($urandom);
            m_b[i]  = DATA_W'($urandom);
        end
        req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
        drive();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},  32'(req_ready),  32'd0);
        check({tag, "_alu_start"},  32'(alu_start),  32'd0);
        check({tag, "_alu_op"},     32'(alu_op),     32'd0);
        check({tag, "_alu_a"},      32'(alu_a),      32'd0);
        check({tag, "_alu_b"},      32'(alu_b),      32'd0);
        check({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
        check({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
        check({tag, "_rsp_carry"},  32'(rsp_carry),  32'd0);
        check({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
    endtask

    // One full transaction from the idle arbitration cycle to the response
    // handshake. dly = extra WAIT cycles before done, bp = backpressure cycles.
    task automatic run_txn(input int dly, input int bp, input bit spur, input bit renew);
        int                w;
        logic [DATA_W:0]   e;
        logic [DATA_W:0]   r;
        logic [OP_W-1:0]   x_op;
        logic [DATA_W-1:0] x_a;
        logic [DATA_W-1:0] x_b;
        #1;
        w = rr_pick(req_valid, m_ptr);
        if (w < 0) begin
            check("no_winner_ready", 32'(req_ready), 32'd0);
            tick();
            return;
        end
        x_op = m_op[w];
        x_a  = m_a[w];
        x_b  = m_b[w];
        e    = alu_ref(x_op, x_a, x_b);
        check("req_ready", 32'(req_ready), 32'(onehot(w)));
        check("idle_start", 32'(alu_start), 32'd0);
        tick();
        // ISSUE cycle: requester may now move on
        if (renew) begin
            set_req(w, OP_W'($urandom), DATA_W'($urandom), DATA_W'($urandom));
        end else begin
            req_valid[w] = 1'b0;
        end
        #1;
        check("alu_start", 32'(alu_start), 32'd1);
        check("alu_op", 32'(alu_op), 32'(x_op));
        check("alu_a", 32'(alu_a), 32'(x_a));
        check("alu_b", 32'(alu_b), 32'(x_b));
        check("busy_ready_issue", 32'(req_ready), 32'd0);
        if (spur) begin
            alu_done   = 1'b1;
            alu_result = DATA_W'($urandom);
            alu_carry  = 1'b1;
        end
        tick();
        alu_done = 1'b0;
        check("start_one_cycle", 32'(alu_start), 32'd0);
        for (int i = 0; i < dly; i++) begin
            check("wait_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        r          = alu_ref(alu_op, alu_a, alu_b);
        alu_result = r[DATA_W-1:0];
        alu_carry  = r[DATA_W];
        alu_done   = 1'b1;
        tick();
        alu_done   = 1'b0;
        alu_result = DATA_W'($urandom);
        alu_carry  = 1'($urandom);
        check("rsp_valid", 32'(rsp_valid), 32'(onehot(w)));
        check("rsp_result", 32'(rsp_result), 32'(e[DATA_W-1:0]));
        check("rsp_carry", 32'(rsp_carry), 32'(e[DATA_W]));
        check("rsp_err", 32'(rsp_err), 32'd0);
        for (int i = 0; i < bp; i++) begin
            rsp_ready = NUM_REQ'($urandom) & ~onehot(w);
            if (spur) begin
                alu_done   = 1'b1;
                alu_result = DATA_W'($urandom);
            end
            tick();
            alu_done = 1'b0;
            check("bp_rsp_valid", 32'(rsp_valid), 32'(onehot(w)));
            check("bp_result", 32'(rsp_result), 32'(e[DATA_W-1:0]));
            check("bp_carry", 32'(rsp_carry), 32'(e[DATA_W]));
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_no_start", 32'(alu_start), 32'd0);
        end
        rsp_ready = onehot(w) | NUM_REQ'($urandom);
        tick();
        rsp_ready = '0;
        check("rsp_cleared", 32'(rsp_valid), 32'd0);
        m_ptr = (w + 1) % NUM_REQ;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        rsp_ready  = '0;
        alu_done   = 1'b0;
        alu_result = '0;
        alu_carry  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, '0, '0, '0);
        m_ptr = 0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single request: 0x0F + 0x01, done two cycles after start
        set_req(0, 3'd0, 8'h0F, 8'h01);
        req_valid = 4'b0001;
        run_txn(1, 2, 1'b0, 1'b0);

        // Carry / wrap on requester 2
        set_req(2, 3'd0, 8'hFF, 8'h01);
        req_valid = 4'b0100;
        run_txn(0, 0, 1'b1, 1'b0);

        // Pointer at 3 with req0 and req3 valid: 3 first, then 0
        set_req(0, 3'd4, 8'hA5, 8'h3C);
        set_req(3, 3'd1, 8'h10, 8'h20);
        req_valid = 4'b1001;
        run_txn(2, 1, 1'b0, 1'b0);
        run_txn(0, 0, 1'b0, 1'b0);

        // Move pointer back to 0 via requester 3
        set_req(3, 3'd3, 8'h81, 8'h18);
        req_valid = 4'b1000;
        run_txn(1, 0, 1'b0, 1'b0);

        // Fairness: everyone continuously valid with distinct operands
        for (int i = 0; i < NUM_REQ; i++) set_req(i, OP_W'(i), DATA_W'(8'h11 * (i + 1)), DATA_W'(8'h07 + i));
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) run_txn(n % 3, 1, 1'b1, 1'b1);

        // Backpressure on requester 2 while requester 0 keeps asking
        set_req(2, 3'd5, 8'hC3, 8'h00);
        set_req(0, 3'd0, 8'h01, 8'h02);
        req_valid = 4'b0101;
        run_txn(0, 5, 1'b1, 1'b0);

        // Reset in WAIT followed by a late alu_done
        set_req(3, 3'd0, 8'h44, 8'h55);
        req_valid = 4'b1001;
        #1;
        check("pre_rst_ready", 32'(req_ready), 32'(onehot(rr_pick(req_valid, m_ptr))));
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("rst_wait");
        rst        = 1'b0;
        req_valid  = '0;
        alu_done   = 1'b1;
        alu_result = 8'h5A;
        alu_carry  = 1'b1;
        tick();
        alu_done = 1'b0;
        check("late_done_rsp", 32'(rsp_valid), 32'd0);
        check("late_done_result", 32'(rsp_result), 32'd0);
        check("late_done_start", 32'(alu_start), 32'd0);
        tick();
        check("late_done_rsp2", 32'(rsp_valid), 32'd0);
        m_ptr = 0;
        req_valid = 4'b1001;
        run_txn(1, 1, 1'b0, 1'b0);

`ifdef ALU_ARB_TIMEOUT_EN
        // ALU never answers: error response after TIMEOUT_CYC WAIT cycles
        set_req(1, 3'd0, 8'h12, 8'h34);
        req_valid = 4'b0010;
        #1;
        check("to_ready", 32'(req_ready), 32'(onehot(1)));
        tick();
        req_valid = '0;
        tick();
        for (int i = 1; i < TIMEOUT_CYC; i++) begin
            check("to_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        check("to_no_rsp_last", 32'(rsp_valid), 32'd0);
        tick();
        check("to_rsp_valid", 32'(rsp_valid), 32'(onehot(1)));
        check("to_rsp_err", 32'(rsp_err), 32'd1);
        check("to_rsp_result", 32'(rsp_result), 32'd0);
        check("to_rsp_carry", 32'(rsp_carry), 32'd0);
        rsp_ready = onehot(1);
        tick();
        rsp_ready = '0;
        check("to_err_clear", 32'(rsp_err), 32'd0);
        check("to_rsp_clear", 32'(rsp_valid), 32'd0);
        m_ptr = 2;
        // done on exactly the limit cycle wins over the timeout
        set_req(2, 3'd0, 8'hFF, 8'hFF);
        req_valid = 4'b0100;
        run_txn(TIMEOUT_CYC - 1, 0, 1'b0, 1'b0);
`endif

        // Randomized traffic
        randomize_reqs();
        for (int n = 0; n < 60; n++) begin
            if (req_valid == '0 || $urandom_range(0, 2) == 0) randomize_reqs();
            run_txn($urandom_range(0, 6), $urandom_range(0, 3),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
